// File: rtl/div_pkg.sv
// Shared types and constants for the iterative restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StRun  = 2'b01,
    StFix  = 2'b10
  } div_state_e;

  // Fill bit for the divide-by-zero quotient (all ones at any width).
  localparam logic DivZeroFill = 1'b1;

  localparam int unsigned DefaultWidth = 32;

  // Step counter must hold the value WIDTH itself.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift {R,Q} left, subtract divisor if it fits.
module div_step #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] r_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] r_o,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH:0]   r_sh;
  logic [WIDTH-1:0] diff;

  assign r_sh = {r_i, q_i[WIDTH-1]};
  // The result is below d_i when taken, so the low WIDTH bits of the difference are exact.
  assign diff = r_sh[WIDTH-1:0] - d_i;

  always_comb begin
    if (r_sh >= {1'b0, d_i}) begin
      r_o = diff;
      q_o = {q_i[WIDTH-2:0], 1'b1};
    end else begin
      r_o = r_sh[WIDTH-1:0];
      q_o = {q_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/seq_divider.sv
// Iterative restoring divider, one quotient bit per clock, start/busy/done handshake.
// Define DIV_SIGNED_EN for two's-complement operands with truncating-division sign fix-up.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = DefaultWidth
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             div_zero_q, div_zero_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_mag, dvs_mag;
  logic [WIDTH-1:0] step_r, step_q;
  logic [WIDTH-1:0] step_r_neg, step_q_neg;

`ifdef DIV_SIGNED_EN
  assign dvd_neg = dividend[WIDTH-1];
  assign dvs_neg = divisor[WIDTH-1];
`else
  assign dvd_neg = 1'b0;
  assign dvs_neg = 1'b0;
`endif

  // |MIN| wraps back to MIN, which is the correct unsigned magnitude.
  assign dvd_mag = dvd_neg ? (~dividend + WIDTH'(1)) : dividend;
  assign dvs_mag = dvs_neg ? (~divisor + WIDTH'(1)) : divisor;

  div_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .r_i (r_q),
    .q_i (q_q),
    .d_i (dvs_q),
    .r_o (step_r),
    .q_o (step_q)
  );

  assign step_q_neg = ~step_q + WIDTH'(1);
  assign step_r_neg = ~step_r + WIDTH'(1);

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    r_d         = r_q;
    q_d         = q_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    div_zero_d  = div_zero_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (divisor == '0) begin
            state_d     = StFix;
            quotient_d  = {WIDTH{DivZeroFill}};
            remainder_d = dividend;
            div_zero_d  = 1'b1;
          end else begin
            state_d = StRun;
            count_d = CntW'(WIDTH);
            r_d     = '0;
            q_d     = dvd_mag;
            dvs_d   = dvs_mag;
            qneg_d  = dvd_neg ^ dvs_neg;
            rneg_d  = dvd_neg;
          end
        end
      end
      StRun: begin
        count_d = count_q - CntW'(1);
        r_d     = step_r;
        q_d     = step_q;
        // Last step: publish sign-corrected results so they are valid in the done cycle.
        if (count_q == CntW'(1)) begin
          state_d     = StFix;
          quotient_d  = qneg_q ? step_q_neg : step_q;
          remainder_d = rneg_q ? step_r_neg : step_r;
          div_zero_d  = 1'b0;
        end
      end
      StFix: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      count_q     <= '0;
      r_q         <= '0;
      q_q         <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      div_zero_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      r_q         <= r_d;
      q_q         <= q_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      div_zero_q  <= div_zero_d;
    end
  end

  assign busy      = (state_q != StIdle);
  assign done      = (state_q == StFix);
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
  assign div_zero  = div_zero_q;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: arithmetic/latency model checked every cycle plus literals.
module tb_seq_divider;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_zero;

  int total = 0;
  int bad   = 0;

  seq_divider #(
    .WIDTH (W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Arithmetic reference straight from the quotient/remainder definitions.
  function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic dz);
    logic signed [W-1:0] sa, sb;
    sa = a;
    sb = b;
    dz = 1'b0;
    if (b == '0) begin
      q  = '1;
      r  = a;
      dz = 1'b1;
    end else begin
`ifdef DIV_SIGNED_EN
      if (a == {1'b1, {(W-1){1'b0}}} && b == '1) begin
        q = a;
        r = '0;
      end else begin
        q = sa / sb;
        r = sa % sb;
      end
`else
      sa = '0;
      sb = '0;
      q  = a / b;
      r  = a % b;
`endif
    end
  endfunction

  // Model: cycles_left counts busy cycles still owed, the last one being the done cycle.
  int           cycles_left = 0;
  logic [W-1:0] exp_q = '0, exp_r = '0, pend_q = '0, pend_r = '0;
  logic         exp_dz = 1'b0, pend_dz = 1'b0;
  logic         chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      cycles_left = 0;
      exp_q       = '0;
      exp_r       = '0;
      exp_dz      = 1'b0;
    end else if (cycles_left > 0) begin
      cycles_left--;
      if (cycles_left == 1) begin
        exp_q  = pend_q;
        exp_r  = pend_r;
        exp_dz = pend_dz;
      end
    end else if (start) begin
      ref_div(dividend, divisor, pend_q, pend_r, pend_dz);
      cycles_left = (divisor == '0) ? 1 : W + 1;
      if (cycles_left == 1) begin
        exp_q  = pend_q;
        exp_r  = pend_r;
        exp_dz = pend_dz;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", W'(busy), W'(cycles_left > 0));
      check("done", W'(done), W'(cycles_left == 1));
      check("quotient", quotient, exp_q);
      check("remainder", remainder, exp_r);
      check("div_zero", W'(div_zero), W'(exp_dz));
    end
  end

  // Launch one division; operands are scrambled while busy. Returns edges from accept to done.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, output int n);
    logic ok;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    n        = 0;
    ok       = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      start    = 1'b0;
      dividend = ~a;
      divisor  = b ^ 32'h5a5a_0001;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL done_timeout: got no done expected done within 100 cycles");
    end
  endtask

  task automatic wait_done(input string name);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got no done expected done within 100 cycles", name);
    end
  endtask

  logic [W-1:0] vec_a [7] = '{32'h0, 32'h7, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000,
                              32'hDEAD_BEEF, 32'h1234_5678};
  logic [W-1:0] vec_b [7] = '{32'h5, 32'h9, 32'h1, 32'h1, 32'hFFFF_FFFF,
                              32'h1234, 32'hFFFF};

  initial begin
    int n;
    rst      = 1'b1;
    start    = 1'b0;
    dividend = '0;
    divisor  = '0;
    repeat (3) @(posedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_busy", W'(busy), '0);
    check("reset_quotient", quotient, '0);
    rst = 1'b0;

    run_op(32'd100, 32'd7, n);
    check("lat_100_7", W'(n), 32'd33);
    check("q_100_7", quotient, 32'd14);
    check("r_100_7", remainder, 32'd2);
    check("dz_100_7", W'(div_zero), '0);
    @(negedge clk);
    check("busy_after_100_7", W'(busy), '0);

    run_op(32'd5, 32'd0, n);
    check("lat_5_0", W'(n), 32'd1);
    check("q_5_0", quotient, 32'hFFFF_FFFF);
    check("r_5_0", remainder, 32'd5);
    check("dz_5_0", W'(div_zero), 32'd1);

`ifdef DIV_SIGNED_EN
    run_op(32'hFFFF_FFF9, 32'd2, n);
    check("q_m7_2", quotient, 32'hFFFF_FFFD);
    check("r_m7_2", remainder, 32'hFFFF_FFFF);
    run_op(32'h8000_0000, 32'hFFFF_FFFF, n);
    check("q_min_m1", quotient, 32'h8000_0000);
    check("r_min_m1", remainder, 32'h0);
    check("dz_min_m1", W'(div_zero), '0);
`else
    run_op(32'hFFFF_FFFF, 32'h10, n);
    check("q_ffff_10", quotient, 32'h0FFF_FFFF);
    check("r_ffff_10", remainder, 32'hF);
`endif

    for (int i = 0; i < 7; i++) run_op(vec_a[i], vec_b[i], n);

    // Starts at cycles 5 and 20 of a running op must be ignored.
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd1000;
    divisor  = 32'd9;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd50;
    divisor  = 32'd5;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    start    = 1'b1;
    dividend = 32'd60;
    divisor  = 32'd0;
    @(negedge clk);
    start = 1'b0;
    wait_done("done_ignore");
    check("q_ignore", quotient, 32'd111);
    check("r_ignore", remainder, 32'd1);
    repeat (3) @(negedge clk);
    check("idle_after_ignore", W'(busy), '0);

    // Start raised during the done cycle is dropped.
    run_op(32'd20, 32'd6, n);
    start    = 1'b1;
    dividend = 32'd77;
    divisor  = 32'd7;
    @(negedge clk);
    start = 1'b0;
    check("busy_done_start", W'(busy), '0);
    check("q_done_start", quotient, 32'd3);

    // Reset mid-operation.
    @(negedge clk);
    start    = 1'b1;
    dividend = 32'd12345;
    divisor  = 32'd67;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("rst_mid_busy", W'(busy), '0);
    check("rst_mid_done", W'(done), '0);
    check("rst_mid_q", quotient, '0);
    check("rst_mid_r", remainder, '0);
    repeat (40) @(negedge clk);
    run_op(32'd9, 32'd3, n);
    check("q_9_3", quotient, 32'd3);
    check("r_9_3", remainder, 32'd0);
    repeat (3) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
